// File: rtl/bp_me_cce_mem_arbiter_if.sv
// CCE-side and memory-side command/response bundle shared between the
// multi-CCE arbiter and whatever drives its CCE and memory ports.
interface bp_me_cce_mem_arbiter_if #(
  parameter int num_cce_p       = 4,
  parameter int mem_msg_width_p = 64
);
  logic [num_cce_p*mem_msg_width_p-1:0] cce_mem_cmd_i;
  logic [num_cce_p-1:0]                 cce_mem_cmd_v_i;
  logic [num_cce_p-1:0]                 cce_mem_cmd_yumi_o;
  logic [mem_msg_width_p-1:0]           cce_mem_resp_o;
  logic [num_cce_p-1:0]                 cce_mem_resp_v_o;
  logic [num_cce_p-1:0]                 cce_mem_resp_ready_i;
  logic [mem_msg_width_p-1:0]           mem_cmd_o;
  logic                                 mem_cmd_v_o;
  logic                                 mem_cmd_ready_i;
  logic [mem_msg_width_p-1:0]           mem_resp_i;
  logic                                 mem_resp_v_i;
  logic                                 mem_resp_yumi_o;

  modport master (
    input  cce_mem_cmd_i, cce_mem_cmd_v_i, cce_mem_resp_ready_i,
           mem_cmd_ready_i, mem_resp_i, mem_resp_v_i,
    output cce_mem_cmd_yumi_o, cce_mem_resp_o, cce_mem_resp_v_o,
           mem_cmd_o, mem_cmd_v_o, mem_resp_yumi_o
  );

  modport slave (
    output cce_mem_cmd_i, cce_mem_cmd_v_i, cce_mem_resp_ready_i,
           mem_cmd_ready_i, mem_resp_i, mem_resp_v_i,
    input  cce_mem_cmd_yumi_o, cce_mem_resp_o, cce_mem_resp_v_o,
           mem_cmd_o, mem_cmd_v_o, mem_resp_yumi_o
  );
endinterface

// File: rtl/bp_me_cce_mem_arbiter.sv
// Round-robin arbiter sharing one CCE-MEM port among num_cce_p CCEs; an in-order
// tag FIFO of grant IDs steers each memory response back to the CCE that issued it.
module bp_me_cce_mem_arbiter #(
  parameter int  num_cce_p         = 4,
  parameter int  mem_msg_width_p   = 64,
  parameter int  max_outstanding_p = 8,
  localparam int cnt_width_lp      = $clog2(max_outstanding_p+1),
  localparam int id_width_lp       = $clog2(num_cce_p),
  localparam int ptr_width_lp      = $clog2(max_outstanding_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  bp_me_cce_mem_arbiter_if.master  bus,
  output logic [cnt_width_lp-1:0]  outstanding_o,
  output logic                     idle_o,
  output logic                     error_o
);

  logic [mem_msg_width_p-1:0] cmd_lane [num_cce_p];
  logic [mem_msg_width_p-1:0] cmd_r;
  logic                       cmd_full_r;
  logic [id_width_lp-1:0]     last_r;
  logic [id_width_lp-1:0]     tag_mem [max_outstanding_p];
  logic [ptr_width_lp-1:0]    head_r;
  logic [ptr_width_lp-1:0]    tail_r;
  logic [cnt_width_lp-1:0]    count_r;
  logic                       error_r;

  logic                       cmd_xfer;
  logic                       fifo_empty;
  logic                       grant_en;
  logic                       grant_found;
  logic                       grant;
  logic [id_width_lp-1:0]     grant_id;
  logic [id_width_lp-1:0]     scan_id;
  logic [id_width_lp-1:0]     head_id;
  logic                       resp_active;
  logic                       pop;

  function automatic logic [ptr_width_lp-1:0] next_ptr(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(max_outstanding_p-1)) ? '0 : p + ptr_width_lp'(1);
  endfunction

  for (genvar k = 0; k < num_cce_p; k++) begin : g_lane
    assign cmd_lane[k] = bus.cce_mem_cmd_i[k*mem_msg_width_p +: mem_msg_width_p];
  end

  // Slot availability looks only at the registered count, so a response
  // popping in the same cycle cannot be reused by a grant until next cycle.
  assign cmd_xfer   = cmd_full_r & bus.mem_cmd_ready_i;
  assign fifo_empty = (count_r == '0);
  assign grant_en   = (~cmd_full_r | cmd_xfer) & (count_r < cnt_width_lp'(max_outstanding_p));

  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    scan_id     = last_r;
    for (int i = 0; i < num_cce_p; i++) begin
      scan_id = (scan_id == id_width_lp'(num_cce_p-1)) ? '0 : scan_id + id_width_lp'(1);
      if (!grant_found && bus.cce_mem_cmd_v_i[scan_id]) begin
        grant_found = 1'b1;
        grant_id    = scan_id;
      end
    end
  end

  assign grant       = grant_found & grant_en & ~reset_i;
  assign head_id     = tag_mem[head_r];
  assign resp_active = bus.mem_resp_v_i & ~fifo_empty;
  assign pop         = resp_active & bus.cce_mem_resp_ready_i[head_id];

  always_comb begin
    bus.cce_mem_cmd_yumi_o = '0;
    bus.cce_mem_resp_v_o   = '0;
    if (grant) begin
      bus.cce_mem_cmd_yumi_o[grant_id] = 1'b1;
    end
    if (resp_active) begin
      bus.cce_mem_resp_v_o[head_id] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cmd_r      <= '0;
      cmd_full_r <= 1'b0;
      last_r     <= id_width_lp'(num_cce_p-1);
      error_r    <= 1'b0;
    end else begin
      if (grant) begin
        cmd_r      <= cmd_lane[grant_id];
        cmd_full_r <= 1'b1;
        last_r     <= grant_id;
      end else if (cmd_xfer) begin
        cmd_full_r <= 1'b0;
      end
      if (bus.mem_resp_v_i && fifo_empty) begin
        error_r <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (grant) begin
        tail_r <= next_ptr(tail_r);
      end
      if (pop) begin
        head_r <= next_ptr(head_r);
      end
      if (grant && !pop) begin
        count_r <= count_r + cnt_width_lp'(1);
      end else if (!grant && pop) begin
        count_r <= count_r - cnt_width_lp'(1);
      end
    end
  end

  // Tag storage needs no reset; entries are only read below the count.
  always_ff @(posedge clk_i) begin
    if (grant) begin
      tag_mem[tail_r] <= grant_id;
    end
  end

  assign bus.mem_cmd_v_o     = cmd_full_r;
  assign bus.mem_cmd_o       = cmd_r;
  assign bus.cce_mem_resp_o  = bus.mem_resp_i;
  assign bus.mem_resp_yumi_o = pop;
  assign outstanding_o       = count_r;
  assign idle_o              = ~cmd_full_r & fifo_empty;
  assign error_o             = error_r;

endmodule

// File: tb/tb_bp_me_cce_mem_arbiter.sv
// Randomized bench for the CCE/memory arbiter: a queue-based reference model
// predicts grants, held commands and response routing; a monitor compares each cycle.
module tb_bp_me_cce_mem_arbiter;
  localparam int NUM = 4;
  localparam int W   = 32;
  localparam int MAX = 8;
  localparam int CW  = $clog2(MAX+1);

  logic          clk_i;
  logic          reset_i;
  logic [CW-1:0] outstanding_o;
  logic          idle_o;
  logic          error_o;

  bp_me_cce_mem_arbiter_if #(.num_cce_p(NUM), .mem_msg_width_p(W)) bus ();

  bp_me_cce_mem_arbiter #(
    .num_cce_p(NUM),
    .mem_msg_width_p(W),
    .max_outstanding_p(MAX)
  ) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .bus(bus),
    .outstanding_o(outstanding_o),
    .idle_o(idle_o),
    .error_o(error_o)
  );

  int checks;
  int failures;
  int timeout_count;
  bit done;

  int           m_last;
  bit           m_held;
  bit           m_error;
  int           m_tags[$];
  logic [W-1:0] m_cmd_q[$];

  int             exp_g;
  int             cand;
  bit             slot_free;
  bit             resp_active;
  logic [NUM-1:0] exp_yumi;
  logic [NUM-1:0] exp_resp_v;
  logic           exp_resp_yumi;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_mem_cmd_v"}, 64'(bus.mem_cmd_v_o), 64'd0);
    checkOutput({tag, "_cmd_yumi"}, 64'(bus.cce_mem_cmd_yumi_o), 64'd0);
    checkOutput({tag, "_resp_v"}, 64'(bus.cce_mem_resp_v_o), 64'd0);
    checkOutput({tag, "_outstanding"}, 64'(outstanding_o), 64'd0);
    checkOutput({tag, "_idle"}, 64'(idle_o), 64'd1);
    checkOutput({tag, "_error"}, 64'(error_o), 64'd0);
  endtask

  task automatic modelReset();
    m_last  = NUM - 1;
    m_held  = 1'b0;
    m_error = 1'b0;
    m_tags.delete();
    m_cmd_q.delete();
  endtask

  // Monitor: compares at the falling edge, then advances the model to the next rising edge.
  initial begin : monitor
    modelReset();
    #1;
    forever begin
      @(negedge clk_i or posedge reset_i);
      if (done && !clk_i) begin
        checkOutput("drain_timeouts", 64'(timeout_count), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
      if (reset_i) begin
        if (clk_i) begin
          #1;
          checkResetOutputs("async_reset");
        end else begin
          checkResetOutputs("reset");
        end
        modelReset();
      end else if (!clk_i) begin
        slot_free = (!m_held || bus.mem_cmd_ready_i) && (m_tags.size() < MAX);
        exp_g = -1;
        if (slot_free) begin
          for (int k = 1; k <= NUM; k++) begin
            cand = (m_last + k) % NUM;
            if (exp_g < 0 && bus.cce_mem_cmd_v_i[cand]) exp_g = cand;
          end
        end
        exp_yumi = '0;
        if (exp_g >= 0) exp_yumi[exp_g] = 1'b1;
        checkOutput("cmd_yumi", 64'(bus.cce_mem_cmd_yumi_o), 64'(exp_yumi));
        checkOutput("mem_cmd_v", 64'(bus.mem_cmd_v_o), 64'(m_held));
        if (m_held) checkOutput("mem_cmd_data", 64'(bus.mem_cmd_o), 64'(m_cmd_q[0]));

        resp_active   = bus.mem_resp_v_i && (m_tags.size() != 0);
        exp_resp_v    = '0;
        exp_resp_yumi = 1'b0;
        if (resp_active) begin
          exp_resp_v[m_tags[0]] = 1'b1;
          exp_resp_yumi = bus.cce_mem_resp_ready_i[m_tags[0]];
          checkOutput("resp_data", 64'(bus.cce_mem_resp_o), 64'(bus.mem_resp_i));
        end
        checkOutput("resp_v", 64'(bus.cce_mem_resp_v_o), 64'(exp_resp_v));
        checkOutput("resp_yumi", 64'(bus.mem_resp_yumi_o), 64'(exp_resp_yumi));
        checkOutput("outstanding", 64'(outstanding_o), 64'(m_tags.size()));
        checkOutput("idle", 64'(idle_o), 64'(!m_held && m_tags.size() == 0));
        checkOutput("error", 64'(error_o), 64'(m_error));

        if (bus.mem_resp_v_i && m_tags.size() == 0) m_error = 1'b1;
        if (m_held && bus.mem_cmd_ready_i) begin
          void'(m_cmd_q.pop_front());
          m_held = 1'b0;
        end
        if (exp_resp_yumi) void'(m_tags.pop_front());
        if (exp_g >= 0) begin
          m_cmd_q.push_back(bus.cce_mem_cmd_i[exp_g*W +: W]);
          m_tags.push_back(exp_g);
          m_last = exp_g;
          m_held = 1'b1;
        end
      end
    end
  end

  // respMode: 0 = no response, 1 = respond only while tags are outstanding, 2 = always respond.
  task automatic applyStimulus(input logic [NUM-1:0] v, input logic rdy, input int respMode,
                               input logic [NUM-1:0] rr);
    @(posedge clk_i);
    #1;
    for (int k = 0; k < NUM; k++) bus.cce_mem_cmd_i[k*W +: W] = $urandom;
    bus.cce_mem_cmd_v_i      = v;
    bus.mem_cmd_ready_i      = rdy;
    bus.cce_mem_resp_ready_i = rr;
    bus.mem_resp_i           = $urandom;
    bus.mem_resp_v_i         = (respMode == 2) || (respMode == 1 && outstanding_o != '0);
  endtask

  task automatic drainAll();
    int n = 0;
    applyStimulus('0, 1'b1, 1, '1);
    while (!(outstanding_o == '0 && !bus.mem_cmd_v_o) && n < 40) begin
      applyStimulus('0, 1'b1, 1, '1);
      n++;
    end
    if (n >= 40) timeout_count++;
  endtask

  initial begin : stimulus
    checks        = 0;
    failures      = 0;
    timeout_count = 0;
    done          = 1'b0;
    reset_i       = 1'b1;
    bus.cce_mem_cmd_i        = '0;
    bus.cce_mem_cmd_v_i      = '0;
    bus.cce_mem_resp_ready_i = '0;
    bus.mem_cmd_ready_i      = 1'b0;
    bus.mem_resp_i           = '0;
    bus.mem_resp_v_i         = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 reset_i = 1'b0;

    $display("[TB] round-robin with memory always ready");
    repeat (24) applyStimulus('1, 1'b1, 1, '1);
    drainAll();

    $display("[TB] async reset with a held command and three tags");
    repeat (3) applyStimulus('1, 1'b1, 0, '1);
    applyStimulus('1, 1'b0, 0, '1);
    @(posedge clk_i);
    #3 reset_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;
    repeat (4) applyStimulus('1, 1'b1, 1, '1);
    drainAll();

    $display("[TB] back-pressure on CCE 2");
    repeat (5) applyStimulus(4'b0100, 1'b0, 0, '1);
    repeat (3) applyStimulus(4'b0100, 1'b1, 0, '1);
    drainAll();

    $display("[TB] tag FIFO full");
    repeat (12) applyStimulus('1, 1'b1, 0, '1);
    applyStimulus('1, 1'b1, 1, '1);
    repeat (2) applyStimulus('1, 1'b1, 0, '1);
    drainAll();

    $display("[TB] in-order response steering");
    applyStimulus(4'b1000, 1'b1, 0, '1);
    applyStimulus(4'b0010, 1'b1, 0, '1);
    applyStimulus(4'b0010, 1'b1, 0, '1);
    applyStimulus(4'b0001, 1'b1, 0, '1);
    applyStimulus('0, 1'b1, 1, 4'b1111);
    applyStimulus('0, 1'b1, 1, 4'b1101);
    repeat (3) applyStimulus('0, 1'b1, 1, 4'b1111);
    drainAll();

    $display("[TB] stray response");
    applyStimulus('0, 1'b1, 2, '1);
    repeat (4) applyStimulus('0, 1'b1, 0, '1);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 300; c++) begin
      applyStimulus(NUM'($urandom), 1'($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 15) == 0) ? 2 : int'($urandom_range(0, 1)),
                    NUM'($urandom | $urandom));
    end
    drainAll();

    @(posedge clk_i);
    #1 reset_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;
    repeat (3) applyStimulus('0, 1'b1, 0, '1);
    done = 1'b1;
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
